// File: rtl/my_pipelined_shift_unit_if.sv
// Request/result bundle for the pipelined shifter: request side, flush, result side.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on requests, out_valid/out_ready on results.
interface my_pipelined_shift_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_rd, flush, out_ready,
        input  in_ready, out_valid, out_data, out_rd
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_rd, flush, out_ready,
        output in_ready, out_valid, out_data, out_rd
    );
endinterface

// File: rtl/my_pipelined_shift_unit.sv
// Two-stage 32-bit shifter (SLL/SRL/SRA/PASS): 16/8 steps into S1, 4/2/1 steps into S2.
// Latency: 2 cycles from accept to out_valid; one result per cycle when unstalled.
// Backpressure: S2 holds while out_ready is low, S1 holds behind it, in_ready drops when both are full.
module my_pipelined_shift_unit (
    input  logic                       clock,
    input  logic                       reset,
    my_pipelined_shift_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef struct packed {
        logic [31:0] dat;
        logic [2:0]  shamt;
        op_e         op;
        logic        sign;
        logic [4:0]  rd;
    } stage_t;

    // One conditional shift step; SRA fills with the sign bit captured at S1 entry.
    function automatic logic [31:0] shift_step(
        input logic [31:0] d,
        input op_e         op,
        input logic        sign,
        input logic        en,
        input logic [4:0]  amt
    );
        logic [31:0] fill;
        logic [31:0] res;
        fill = sign ? ~(32'hFFFF_FFFF >> amt) : 32'h0;
        res  = d;
        if (en) begin
            case (op)
                OP_SLL:  res = d << amt;
                OP_SRL:  res = d >> amt;
                OP_SRA:  res = (d >> amt) | fill;
                default: res = d;
            endcase
        end
        return res;
    endfunction

    stage_t      s1_q, s2_q;
    stage_t      s1_nxt, s2_nxt;
    logic        s1_vld, s2_vld;
    logic        s2_accept;
    logic        s1_move;
    logic        in_acc;
    logic [31:0] s1_mid;
    logic [31:0] s2_mid_a, s2_mid_b;
    logic        s2_unused;

    assign s2_accept   = !s2_vld || bus.out_ready;
    assign s1_move     = s1_vld && s2_accept;
    assign bus.in_ready = !bus.flush && (!s1_vld || s2_accept);
    assign in_acc      = bus.in_valid && bus.in_ready;

    always_comb begin
        s1_nxt       = '0;
        s1_nxt.op    = op_e'(bus.in_op);
        s1_nxt.sign  = bus.in_data[31];
        s1_nxt.rd    = bus.in_rd;
        s1_nxt.shamt = bus.in_shamt[2:0];
        s1_mid       = shift_step(bus.in_data, s1_nxt.op, s1_nxt.sign, bus.in_shamt[4], 5'd16);
        s1_nxt.dat   = shift_step(s1_mid, s1_nxt.op, s1_nxt.sign, bus.in_shamt[3], 5'd8);
    end

    always_comb begin
        s2_nxt       = '0;
        s2_nxt.op    = s1_q.op;
        s2_nxt.sign  = s1_q.sign;
        s2_nxt.rd    = s1_q.rd;
        s2_nxt.shamt = 3'd0;
        s2_mid_a     = shift_step(s1_q.dat, s1_q.op, s1_q.sign, s1_q.shamt[2], 5'd4);
        s2_mid_b     = shift_step(s2_mid_a, s1_q.op, s1_q.sign, s1_q.shamt[1], 5'd2);
        s2_nxt.dat   = shift_step(s2_mid_b, s1_q.op, s1_q.sign, s1_q.shamt[0], 5'd1);
    end

    // Flush wins over every transfer; data registers may still move since only valids are visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            if (bus.flush) begin
                s1_vld <= 1'b0;
                s2_vld <= 1'b0;
            end else begin
                if (s2_accept) s2_vld <= s1_vld;
                if (in_acc)       s1_vld <= 1'b1;
                else if (s1_move) s1_vld <= 1'b0;
            end
            if (s1_move) s2_q <= s2_nxt;
            if (in_acc)  s1_q <= s1_nxt;
        end
    end

    assign bus.out_valid = s2_vld;
    assign bus.out_data  = s2_q.dat;
    assign bus.out_rd    = s2_q.rd;

    // S2 keeps the full stage record; these fields are not needed past the last step.
    assign s2_unused = ^{s2_q.shamt, s2_q.op, s2_q.sign};

endmodule

// File: doc/my_pipelined_shift_unit.md
MY_PIPELINED_SHIFT_UNIT -- requirements
Module: my_pipelined_shift_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: request present.
- in_ready, out, 1: block accepts a request this cycle.
- in_data, in, 32: operand to shift.
- in_shamt, in, 5: shift amount, 0-31.
- in_op, in, 2: 00 SLL, 01 SRL, 10 SRA, 11 PASS.
- in_rd, in, 5: destination tag, carried unchanged.
- flush, in, 1: synchronous kill of all in-flight requests.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, 32: shifted result.
- out_rd, out, 5: tag of the result.
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 The block SHALL contain two registered stages, S1 and S2, each holding a valid bit, the partial data, the remaining shamt[2:0], the op and the tag.
REQ-005 Entering S1, the block SHALL apply the shamt[4] (16) and shamt[3] (8) shift steps combinationally.
REQ-006 Entering S2, the block SHALL apply the shamt[2] (4), shamt[1] (2) and shamt[0] (1) steps, in that order.
REQ-007 Shift semantics SHALL be as follows:
- SLL: zero-fill from the LSB.
- SRL: zero-fill from the MSB.
- SRA: fill with in_data[31], the sign bit, which is captured in S1 and used at every step.
- PASS: data unchanged, whatever in_shamt is.
REQ-008 A shamt of 0 SHALL return in_data unchanged for every op.
REQ-009 The results SHALL be correct at shamt 31, for example SRA of 0x80000000 by 31 gives 0xFFFFFFFF.
REQ-010 S2 SHALL accept new content when s2_accept = !s2_valid || out_ready.
REQ-011 S1 SHALL move into S2 when s1_valid && s2_accept; otherwise S1 SHALL hold its contents.
REQ-012 The handshake signals SHALL be defined as follows:
- in_ready = !flush && (!s1_valid || s2_accept).
- A request is accepted on a rising edge where in_valid && in_ready.
REQ-013 out_valid SHALL equal s2_valid, and out_data and out_rd SHALL be driven directly from S2 registers, with no combinational path from the inputs.
REQ-014 Latency SHALL be 2 cycles: a request accepted at edge N appears on out_valid after edge N+1 when the pipe is unstalled.
REQ-015 With out_ready held high, throughput SHALL be one result per cycle.
REQ-016 While out_valid && !out_ready, out_data and out_rd SHALL hold stable, and S1 SHALL hold if it is valid.
REQ-017 When S1 and S2 are both valid and out_ready is low, in_ready SHALL be low.
REQ-018 When out_ready is high on the same edge as an accept into S1 and an S1-to-S2 move, all three transfers SHALL occur on that edge with no bubble and no loss.
REQ-019 A flush sampled high SHALL clear s1_valid and s2_valid at that edge, even if out_ready is high on that edge.
REQ-020 A result discarded by flush SHALL never be reported as accepted; in_ready SHALL be low during flush, so no new request is taken on that edge.
REQ-021 Data and tag registers MAY update without valid set; only the valid bits are architecturally visible.

Reset
REQ-022 While reset is low, s1_valid, s2_valid and out_valid SHALL be 0, and out_data and out_rd SHALL be 0, asynchronously.
REQ-023 in_ready SHALL be 1 during reset and after release, provided flush is low.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight requests, and no stale result SHALL appear after reset is released.

Verification
REQ-025 The bench SHALL cover single ops: SLL 0x0000_0001 by 31 -> 0x8000_0000; SRL 0x8000_0000 by 4 -> 0x0800_0000; SRA 0x8000_0000 by 4 -> 0xF800_0000; PASS 0x1234_5678 with shamt 7 -> 0x1234_5678. Each result appears 2 cycles after accept with its tag.
REQ-026 The bench SHALL cover streaming: 8 back-to-back requests with out_ready=1 -> 8 results on consecutive cycles, in order, with tags matching.
REQ-027 The bench SHALL cover backpressure: 3 requests with out_ready=0 -> the first two are accepted, in_ready falls, and out_data holds. On raising out_ready, all 3 results drain in order.
REQ-028 The bench SHALL cover flush: flush while both stages are valid and out_ready=1 -> out_valid=0 next cycle, no flushed tag ever appears, and in_ready=0 during the flush cycle.
REQ-029 The bench SHALL cover reset mid-stream: reset low for 1 cycle with 2 requests in flight -> out_valid=0 immediately, outputs 0, and the next accepted request completes normally.
REQ-030 The bench SHALL run a randomized sweep of 10k requests over all ops and shamt values with random out_ready, and every result SHALL match the reference model.
